// File: rtl/alu.sv
// 64-bit integer ALU: result and zero/negative/carry/overflow flags registered on the rising edge.
// Latency: one cycle. There is no handshake; a new operation is accepted every cycle.
module alu #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_PASSB = 4'b1011
  } op_e;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_slt;
  logic               w_sltu;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;

  logic [WIDTH-1:0]   r_out;
  logic               r_zero;
  logic               r_negative;
  logic               r_carry;
  logic               r_overflow;

  // Subtraction is a + ~b + 1, so its top bit is the inverted borrow.
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shamt = b[SHAMT_W-1:0];
  assign w_slt   = $signed(a) < $signed(b);
  assign w_sltu  = a < b;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_NOR:   w_res = ~(a | b);
      OP_SLL:   w_res = a << w_shamt;
      OP_SRL:   w_res = a >> w_shamt;
      OP_SRA:   w_res = $unsigned($signed(a) >>> w_shamt);
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_PASSB: w_res = b;
      default:  w_res = '0;
    endcase
  end

  // Flags come from the same value being registered so they always agree with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_zero     <= 1'b1;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_out      <= w_res;
      r_zero     <= (w_res == '0);
      r_negative <= w_res[WIDTH-1];
      r_carry    <= w_carry;
      r_overflow <= w_ovf;
    end
  end

  assign out      = r_out;
  assign zero     = r_zero;
  assign negative = r_negative;
  assign carry    = r_carry;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: the driver queues expected results, a monitor checks them one edge later.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  op;
  logic [63:0] out;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  typedef struct {
    string       name;
    logic [63:0] out;
    logic [3:0]  flags;  // {zero, negative, carry, overflow}
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  alu #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .out(out), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge; the DUT samples on the following rising edge.
  task automatic issue(input string nm, input logic r, input logic [3:0] o,
                       input logic [63:0] aa, input logic [63:0] bb,
                       input logic [63:0] eo, input logic ec, input logic ev);
    exp_t e;
    @(negedge clk);
    rst = r;
    op  = o;
    a   = aa;
    b   = bb;
    e.name  = nm;
    e.out   = eo;
    e.flags = {(eo == 64'd0), eo[63], ec, ev};
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      logic [3:0] got;
      e   = exp_q.pop_front();
      got = {zero, negative, carry, overflow};
      checks++;
      if (out !== e.out) begin
        errors++;
        $display("FAIL %s out: got %h expected %h", e.name, out, e.out);
      end
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL %s flags(z,n,c,v): got %b expected %b", e.name, got, e.flags);
      end
    end
  end

  initial begin
    rst = 1'b1;
    op  = 4'd0;
    a   = 64'd0;
    b   = 64'd0;

    issue("reset",        1'b1, 4'b0000, 64'd5, 64'd6, 64'd0, 1'b0, 1'b0);
    issue("add_0_0",      1'b0, 4'b0000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    issue("add_1_2",      1'b0, 4'b0000, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
    issue("add_wrap",     1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
    issue("add_ovf",      1'b0, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue("sub_5_7",      1'b0, 4'b0001, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue("sub_7_5",      1'b0, 4'b0001, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0);
    issue("sub_ovf",      1'b0, 4'b0001, 64'h8000_0000_0000_0000, 64'd1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    issue("sub_eq",       1'b0, 4'b0001, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0);
    issue("slt",          1'b0, 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0);
    issue("sltu",         1'b0, 4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0);
    issue("and",          1'b0, 4'b0010, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0);
    issue("or",           1'b0, 4'b0011, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1'b0);
    issue("xor",          1'b0, 4'b0100, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1'b0);
    issue("nor",          1'b0, 4'b0101, 64'hF0F0, 64'hFF00, 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b0);
    issue("sll_1",        1'b0, 4'b0110, 64'h8000_0000_0000_0001, 64'h41, 64'h2, 1'b0, 1'b0);
    issue("srl_1",        1'b0, 4'b0111, 64'h8000_0000_0000_0001, 64'h41,
          64'h4000_0000_0000_0000, 1'b0, 1'b0);
    issue("sra_1",        1'b0, 4'b1000, 64'h8000_0000_0000_0001, 64'h41,
          64'hC000_0000_0000_0000, 1'b0, 1'b0);
    issue("sll_0",        1'b0, 4'b0110, 64'h8000_0000_0000_0001, 64'h0,
          64'h8000_0000_0000_0001, 1'b0, 1'b0);
    issue("srl_0",        1'b0, 4'b0111, 64'h8000_0000_0000_0001, 64'h0,
          64'h8000_0000_0000_0001, 1'b0, 1'b0);
    issue("sra_0",        1'b0, 4'b1000, 64'h8000_0000_0000_0001, 64'h0,
          64'h8000_0000_0000_0001, 1'b0, 1'b0);
    issue("sra_63",       1'b0, 4'b1000, 64'h8000_0000_0000_0000, 64'h3F,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    issue("passb",        1'b0, 4'b1011, 64'h1234, 64'hDEAD_BEEF_0000_1000,
          64'hDEAD_BEEF_0000_1000, 1'b0, 1'b0);
    issue("rst_mid_add",  1'b1, 4'b0000, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0);
    issue("add_after_rst",1'b0, 4'b0000, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0);
    issue("reserved_d",   1'b0, 4'b1101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, 1'b0, 1'b0);
    issue("reserved_f",   1'b0, 4'b1111, 64'h1, 64'h1, 64'd0, 1'b0, 1'b0);

    @(negedge clk);
    op = 4'b0000;
    a  = 64'd0;
    b  = 64'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
